// File: rtl/sdf_delay_ram.sv
// rtl/sdf_delay_ram.sv - multi-channel DEPTH-beat sample delay line on an inferred simple dual-port RAM
module sdf_delay_ram #(
  parameter int WIDTH      = 16,
  parameter int NCH        = 2,
  parameter int DEPTH      = 16,
  parameter int OUT_REG    = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [NCH*WIDTH-1:0]    in_data,
  output logic                    out_valid,
  output logic [NCH*WIDTH-1:0]    out_data,
  output logic                    primed,
  output logic [ADDR_WIDTH:0]     fill_cnt
);

  localparam int                    DW        = NCH * WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   FILL_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("sdf_delay_ram: DEPTH must be >= 2");
    end
  endgenerate

  logic [ADDR_WIDTH-1:0] ptr;
  logic                  accept;
  logic                  full;
  logic [DW-1:0]         mem [DEPTH];
  logic [DW-1:0]         ram_q;
  logic                  rd_valid;

  assign accept = in_valid & ~flush & ~rst;
  assign full   = (fill_cnt == FILL_FULL);

  // Explicit wrap compare so non-power-of-two depths cycle through exactly DEPTH slots.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ptr      <= '0;
      fill_cnt <= '0;
      primed   <= 1'b0;
    end else if (in_valid) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      if (!full) begin
        fill_cnt <= fill_cnt + 1'b1;
        primed   <= (fill_cnt == FILL_FULL - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ptr] <= in_data;
    end
  end

  // Separate read register sees the pre-write contents: read-first returns the DEPTH-old sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q <= '0;
    end else if (accept) begin
      ram_q <= mem[ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= accept & full;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] out_q;
      logic          out_v;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
          out_v <= 1'b0;
        end else if (flush) begin
          out_v <= 1'b0;
        end else begin
          out_v <= rd_valid;
          if (rd_valid) begin
            out_q <= ram_q;
          end
        end
      end

      assign out_valid = out_v;
      assign out_data  = out_q;
    end else begin : g_no_out_reg
      assign out_valid = rd_valid;
      assign out_data  = ram_q;
    end
  endgenerate

endmodule

// File: tb/tb_sdf_delay_ram.sv
// tb/tb_sdf_delay_ram.sv - self-checking bench for sdf_delay_ram across four depth/output-register configurations
module tb_sdf_delay_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;

  logic        ov [4];
  logic [31:0] od [4];
  logic        pr [4];
  logic [4:0]  fc0;
  logic [3:0]  fc1;
  logic [3:0]  fc2;
  logic [1:0]  fc3;
  logic [4:0]  fcv [4];

  assign fcv[0] = fc0;
  assign fcv[1] = {1'b0, fc1};
  assign fcv[2] = {1'b0, fc2};
  assign fcv[3] = {3'b0, fc3};

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sdf_delay_ram #(.WIDTH(16), .NCH(2), .DEPTH(16), .OUT_REG(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .primed(pr[0]), .fill_cnt(fc0));
  sdf_delay_ram #(.WIDTH(16), .NCH(2), .DEPTH(5), .OUT_REG(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .primed(pr[1]), .fill_cnt(fc1));
  sdf_delay_ram #(.WIDTH(16), .NCH(2), .DEPTH(8), .OUT_REG(1)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[2]), .out_data(od[2]), .primed(pr[2]), .fill_cnt(fc2));
  sdf_delay_ram #(.WIDTH(16), .NCH(2), .DEPTH(2), .OUT_REG(0)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[3]), .out_data(od[3]), .primed(pr[3]), .fill_cnt(fc3));

  function automatic int dep(input int i);
    case (i)
      0:       return 16;
      1:       return 5;
      2:       return 8;
      default: return 2;
    endcase
  endfunction

  function automatic bit oreg(input int i);
    return (i == 0) || (i == 2);
  endfunction

  // Reference: history of accepted beats since rst/flush; a beat emits hist[cnt-DEPTH]
  // when at least DEPTH beats preceded it.
  int          cnt    [4];
  logic        cur_v  [4];
  logic [31:0] cur_d  [4];
  logic        dchk   [4];
  logic        pend_v [4];
  logic [31:0] pend_d [4];
  logic [31:0] hist   [4][4096];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic model_edge(input logic r, input logic f, input logic v, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        cnt[i] = 0; cur_v[i] = 1'b0; pend_v[i] = 1'b0; cur_d[i] = '0; dchk[i] = 1'b1;
      end else if (f) begin
        cnt[i] = 0; cur_v[i] = 1'b0; pend_v[i] = 1'b0;
      end else begin
        logic        qual;
        logic [31:0] val;
        qual = v && (cnt[i] >= dep(i));
        val  = qual ? hist[i][(cnt[i] - dep(i)) & 4095] : '0;
        if (oreg(i)) begin
          cur_v[i] = pend_v[i];
          if (pend_v[i]) cur_d[i] = pend_d[i];
          pend_v[i] = qual;
          pend_d[i] = val;
        end else begin
          cur_v[i] = qual;
          if (v) begin
            dchk[i] = qual;
            if (qual) cur_d[i] = val;
          end
        end
        if (v) begin
          hist[i][cnt[i] & 4095] = d;
          cnt[i]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      int fill;
      fill = (cnt[i] < dep(i)) ? cnt[i] : dep(i);
      check($sformatf("dut%0d_out_valid", i), {31'b0, ov[i]}, {31'b0, cur_v[i]});
      check($sformatf("dut%0d_primed", i), {31'b0, pr[i]}, {31'b0, (cnt[i] >= dep(i))});
      check($sformatf("dut%0d_fill_cnt", i), {27'b0, fcv[i]}, 32'(fill));
      if (dchk[i]) check($sformatf("dut%0d_out_data", i), od[i], cur_d[i]);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] d);
    rst = r; flush = f; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
    model_edge(r, f, v, d);
    check_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic        in_valid;
    logic [31:0] in_data;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_fill;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int first_a, first_b, pulses_a, pulses_b, pulses_c, first_c;
    logic [31:0] first_c_data;

    vecs[0] = '{1'b1, 32'hA, 1'b0, 32'h0, 2'd1};
    vecs[1] = '{1'b1, 32'hB, 1'b0, 32'h0, 2'd2};
    vecs[2] = '{1'b1, 32'hC, 1'b1, 32'hA, 2'd2};
    vecs[3] = '{1'b1, 32'hD, 1'b1, 32'hB, 2'd2};
    vecs[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 2'd2};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 2'd2};

    do_reset();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_out_data_dut%0d", i), od[i], 32'h0);
      check($sformatf("reset_fill_dut%0d", i), {27'b0, fcv[i]}, 32'h0);
    end

    // Read-first collision at DEPTH=2
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, vecs[k].in_valid, vecs[k].in_data);
      check($sformatf("vec%0d_valid", k), {31'b0, ov[3]}, {31'b0, vecs[k].exp_valid});
      check($sformatf("vec%0d_fill", k), {30'b0, fc3}, {30'b0, vecs[k].exp_fill});
      if (vecs[k].exp_valid) check($sformatf("vec%0d_data", k), od[3], vecs[k].exp_data);
    end

    // Continuous stream, {imag=n, real=n+1000}
    do_reset();
    first_a = -1; first_b = -1; pulses_a = 0; pulses_b = 0;
    for (int n = 0; n < 42; n++) begin
      if (n < 40) step(1'b0, 1'b0, 1'b1, {16'(n), 16'(n + 1000)});
      else        step(1'b0, 1'b0, 1'b0, '0);
      if (ov[0]) begin
        if (first_a < 0) first_a = n;
        pulses_a++;
      end
      if (ov[1]) begin
        if (first_b < 0) first_b = n;
        pulses_b++;
      end
      if (n == 14) check("primed_a_before", {31'b0, pr[0]}, 32'd0);
      if (n == 15) check("primed_a_after", {31'b0, pr[0]}, 32'd1);
      if (n == 17) check("first_a_data", od[0], {16'd0, 16'd1000});
    end
    check("first_pulse_a", 32'(first_a), 32'd17);
    check("pulses_a", 32'(pulses_a), 32'd24);
    check("first_pulse_b", 32'(first_b), 32'd5);
    check("pulses_b", 32'(pulses_b), 32'd35);

    // Gapped beats: delay counts accepted beats only
    do_reset();
    pulses_c = 0;
    for (int n = 0; n <= 20; n++) begin
      step(1'b0, 1'b0, 1'b1, 32'(n));
      if (ov[2]) pulses_c++;
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'b0, 1'b0, '0);
        if (ov[2]) pulses_c++;
      end
    end
    check("gapped_pulses_c", 32'(pulses_c), 32'd13);
    check("gapped_hold_c", od[2], 32'd12);

    // Flush with a simultaneous beat
    do_reset();
    for (int n = 0; n < 12; n++) step(1'b0, 1'b0, 1'b1, 32'(n));
    step(1'b0, 1'b1, 1'b1, 32'd12);
    check("flush_fill_c", {28'b0, fc2}, 32'd0);
    check("flush_primed_c", {31'b0, pr[2]}, 32'd0);
    first_c = -1; first_c_data = '0;
    for (int k = 0; k < 11; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'(100 + k));
      if (ov[2] && first_c < 0) begin
        first_c = k;
        first_c_data = od[2];
      end
    end
    check("post_flush_first_c", 32'(first_c), 32'd9);
    check("post_flush_data_c", first_c_data, 32'd100);

    // Reset mid-stream right after an accepted, qualifying beat
    step(1'b0, 1'b0, 1'b1, 32'd200);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_mid_valid_dut%0d", i), {31'b0, ov[i]}, 32'd0);
      check($sformatf("rst_mid_data_dut%0d", i), od[i], 32'd0);
      check($sformatf("rst_mid_fill_dut%0d", i), {27'b0, fcv[i]}, 32'd0);
      check($sformatf("rst_mid_primed_dut%0d", i), {31'b0, pr[i]}, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    check("rst_mid_suppress_a", {31'b0, ov[0]}, 32'd0);
    check("rst_mid_suppress_c", {31'b0, ov[2]}, 32'd0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 800; k++) begin
      logic r, f, v;
      r = ($urandom_range(0, 149) == 0);
      f = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 9) < 7);
      step(r, f, v, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
